control_unit: RTL and testbench

Multicycle main control FSM for the MIPS datapath. Sequences PC, IR, A/B, ALUOut, EPC, register file, memory and the shift register through fetch, decode, execute, memory and write-back steps for a fixed instruction subset. All datapath control signals originate here; it sits beside the datapath inside the CPU top level and reads only opcode, funct and ALU flags.

---
 rtl/control_unit.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Multicycle main control FSM for the MIPS datapath. Walks each
//                instruction through fetch/decode/execute/memory/write-back
//                and drives every datapath select and write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       PC_write,
    output logic       wr,
    output logic       AB_load,
    output logic       aluout_load,
    output logic       EPC_load,
    output logic       sel_ir,
    output logic       reg_write,
    output logic       sel_alusrca,
    output logic [1:0] sel_alusrcb,
    output logic       sel_iord,
    output logic [1:0] sel_pc_source,
    output logic [1:0] sel_regdst,
    output logic [1:0] sel_memtoreg,
    output logic       sel_shift_src,
    output logic [1:0] sel_shift_amt,
    output logic [2:0] sel_shift_reg,
    output logic [2:0] alu_op,
    output logic       exc_cause
);

    localparam logic [4:0] S_RESET      = 5'd0;
    localparam logic [4:0] S_FETCH1     = 5'd1;
    localparam logic [4:0] S_FETCH2     = 5'd2;
    localparam logic [4:0] S_FETCH3     = 5'd3;
    localparam logic [4:0] S_DECODE     = 5'd4;
    localparam logic [4:0] S_EXEC_R     = 5'd5;
    localparam logic [4:0] S_WB_R       = 5'd6;
    localparam logic [4:0] S_EXEC_ADDI  = 5'd7;
    localparam logic [4:0] S_WB_I       = 5'd8;
    localparam logic [4:0] S_SHIFT_LOAD = 5'd9;
    localparam logic [4:0] S_SHIFT_OP   = 5'd10;
    localparam logic [4:0] S_WB_SHIFT   = 5'd11;
    localparam logic [4:0] S_JR         = 5'd12;
    localparam logic [4:0] S_J          = 5'd13;
    localparam logic [4:0] S_BRANCH     = 5'd14;
    localparam logic [4:0] S_MEM_ADDR   = 5'd15;
    localparam logic [4:0] S_MEM_RD1    = 5'd16;
    localparam logic [4:0] S_MEM_RD2    = 5'd17;
    localparam logic [4:0] S_WB_MEM     = 5'd18;
    localparam logic [4:0] S_MEM_WR     = 5'd19;
    localparam logic [4:0] S_EXCEPTION  = 5'd20;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MEM    = 2'b01;
    localparam logic [1:0] M2R_SHIFT  = 2'b10;

    localparam logic [2:0] SHREG_HOLD = 3'b000;
    localparam logic [2:0] SHREG_LOAD = 3'b001;
    localparam logic [2:0] SHREG_SLL  = 3'b010;
    localparam logic [2:0] SHREG_SRL  = 3'b011;

    localparam logic CAUSE_INVALID  = 1'b0;
    localparam logic CAUSE_OVERFLOW = 1'b1;

    logic [4:0] state;
    logic [4:0] state_next;
    logic       exc_set;
    logic       exc_cause_next;
    logic       is_rtype;
    logic       is_arith_ovf;
    logic       branch_taken;

    assign is_rtype     = (opcode == OP_RTYPE);
    // "and" cannot overflow, so only add/sub consult the overflow flag
    assign is_arith_ovf = (funct == FN_ADD) || (funct == FN_SUB);
    assign branch_taken = ((opcode == OP_BEQ) &&  alu_zero) ||
                          ((opcode == OP_BNE) && !alu_zero);

    // ------------------------------------------------------------------------
    // State and exception-cause registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            exc_cause <= CAUSE_INVALID;
        end else begin
            state <= state_next;
            if (exc_set) begin
                exc_cause <= exc_cause_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        exc_set        = 1'b0;
        exc_cause_next = CAUSE_INVALID;
        case (state)
            S_RESET:  state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_FETCH3;
            S_FETCH3: state_next = S_DECODE;
            S_DECODE: begin
                if (is_rtype) begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND: state_next = S_EXEC_R;
                        FN_SLL, FN_SRL:         state_next = S_SHIFT_LOAD;
                        FN_JR:                  state_next = S_JR;
                        default: begin
                            state_next     = S_EXCEPTION;
                            exc_set        = 1'b1;
                            exc_cause_next = CAUSE_INVALID;
                        end
                    endcase
                end else begin
                    case (opcode)
                        OP_J:           state_next = S_J;
                        OP_BEQ, OP_BNE: state_next = S_BRANCH;
                        OP_ADDI:        state_next = S_EXEC_ADDI;
                        OP_LW, OP_SW:   state_next = S_MEM_ADDR;
                        default: begin
                            state_next     = S_EXCEPTION;
                            exc_set        = 1'b1;
                            exc_cause_next = CAUSE_INVALID;
                        end
                    endcase
                end
            end
            S_EXEC_R: begin
                if (is_arith_ovf && alu_overflow) begin
                    state_next     = S_EXCEPTION;
                    exc_set        = 1'b1;
                    exc_cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = S_WB_R;
                end
            end
            S_EXEC_ADDI: begin
                if (alu_overflow) begin
                    state_next     = S_EXCEPTION;
                    exc_set        = 1'b1;
                    exc_cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = S_WB_I;
                end
            end
            S_SHIFT_LOAD: state_next = S_SHIFT_OP;
            S_SHIFT_OP:   state_next = S_WB_SHIFT;
            S_MEM_ADDR:   state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD1;
            S_MEM_RD1:    state_next = S_MEM_RD2;
            S_MEM_RD2:    state_next = S_WB_MEM;
            S_WB_R, S_WB_I, S_WB_SHIFT, S_WB_MEM,
            S_JR, S_J, S_BRANCH, S_MEM_WR, S_EXCEPTION:
                          state_next = S_FETCH1;
            default:      state_next = S_RESET;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore, plus funct/opcode/alu_zero where the step needs it)
    // ------------------------------------------------------------------------
    always_comb begin
        PC_write      = 1'b0;
        wr            = 1'b0;
        AB_load       = 1'b0;
        aluout_load   = 1'b0;
        EPC_load      = 1'b0;
        sel_ir        = 1'b0;
        reg_write     = 1'b0;
        sel_alusrca   = 1'b0;
        sel_alusrcb   = SRCB_B;
        sel_iord      = 1'b0;
        sel_pc_source = PCSRC_ALU;
        sel_regdst    = REGDST_RT;
        sel_memtoreg  = M2R_ALUOUT;
        sel_shift_src = 1'b0;
        sel_shift_amt = 2'b00;
        sel_shift_reg = SHREG_HOLD;
        alu_op        = ALU_PASS_A;
        case (state)
            S_FETCH3: begin
                sel_ir        = 1'b1;
                sel_alusrcb   = SRCB_FOUR;
                alu_op        = ALU_ADD;
                PC_write      = 1'b1;
                sel_pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // Branch target is computed speculatively while A/B load
                AB_load     = 1'b1;
                sel_alusrcb = SRCB_IMM_SH;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
            end
            S_EXEC_R: begin
                sel_alusrca = 1'b1;
                sel_alusrcb = SRCB_B;
                aluout_load = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_WB_R: begin
                sel_memtoreg = M2R_ALUOUT;
                sel_regdst   = REGDST_RD;
                reg_write    = 1'b1;
            end
            S_EXEC_ADDI: begin
                sel_alusrca = 1'b1;
                sel_alusrcb = SRCB_IMM;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
            end
            S_WB_I: begin
                sel_memtoreg = M2R_ALUOUT;
                sel_regdst   = REGDST_RT;
                reg_write    = 1'b1;
            end
            S_SHIFT_LOAD: begin
                sel_shift_src = 1'b0;
                sel_shift_amt = 2'b00;
                sel_shift_reg = SHREG_LOAD;
            end
            S_SHIFT_OP: begin
                sel_shift_reg = (funct == FN_SRL) ? SHREG_SRL : SHREG_SLL;
            end
            S_WB_SHIFT: begin
                sel_memtoreg = M2R_SHIFT;
                sel_regdst   = REGDST_RD;
                reg_write    = 1'b1;
            end
            S_JR: begin
                sel_alusrca   = 1'b1;
                alu_op        = ALU_PASS_A;
                sel_pc_source = PCSRC_ALU;
                PC_write      = 1'b1;
            end
            S_J: begin
                sel_pc_source = PCSRC_JUMP;
                PC_write      = 1'b1;
            end
            S_BRANCH: begin
                sel_alusrca = 1'b1;
                sel_alusrcb = SRCB_B;
                alu_op      = ALU_SUB;
                if (branch_taken) begin
                    PC_write      = 1'b1;
                    sel_pc_source = PCSRC_ALUOUT;
                end
            end
            S_MEM_ADDR: begin
                sel_alusrca = 1'b1;
                sel_alusrcb = SRCB_IMM;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
            end
            S_MEM_RD1, S_MEM_RD2: begin
                sel_iord = 1'b1;
            end
            S_WB_MEM: begin
                sel_iord     = 1'b1;
                sel_memtoreg = M2R_MEM;
                sel_regdst   = REGDST_RT;
                reg_write    = 1'b1;
            end
            S_MEM_WR: begin
                sel_iord = 1'b1;
                wr       = 1'b1;
            end
            S_EXCEPTION: begin
                // PC already advanced by 4 in FETCH3; EPC gets the faulting PC
                sel_alusrcb   = SRCB_FOUR;
                alu_op        = ALU_SUB;
                EPC_load      = 1'b1;
                PC_write      = 1'b1;
                sel_pc_source = PCSRC_EXC;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit; expected control words
//                per cycle are queued per instruction and compared cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       wr;
        logic       ab_load;
        logic       aluout_load;
        logic       epc_load;
        logic       ir;
        logic       reg_write;
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       shsrc;
        logic [1:0] shamt;
        logic [2:0] shreg;
        logic [2:0] aluop;
        logic       exc;
    } ctl_t;

    localparam int T_RST = 0,  T_F1 = 1,  T_F2 = 2,  T_F3 = 3,  T_DEC = 4;
    localparam int T_EXR = 5,  T_WBR = 6, T_EXI = 7, T_WBI = 8, T_SHL = 9;
    localparam int T_SHO = 10, T_WBS = 11, T_JR = 12, T_J = 13, T_BR = 14;
    localparam int T_MA  = 15, T_R1 = 16, T_R2 = 17, T_WBM = 18, T_MW = 19;
    localparam int T_EXC = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       alu_zero, alu_overflow;
    logic       PC_write, wr, AB_load, aluout_load, EPC_load, sel_ir, reg_write;
    logic       sel_alusrca, sel_iord, sel_shift_src, exc_cause;
    logic [1:0] sel_alusrcb, sel_pc_source, sel_regdst, sel_memtoreg, sel_shift_amt;
    logic [2:0] sel_shift_reg, alu_op;

    ctl_t obs;
    ctl_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic cur_exc  = 1'b0;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .PC_write(PC_write), .wr(wr), .AB_load(AB_load), .aluout_load(aluout_load),
        .EPC_load(EPC_load), .sel_ir(sel_ir), .reg_write(reg_write),
        .sel_alusrca(sel_alusrca), .sel_alusrcb(sel_alusrcb), .sel_iord(sel_iord),
        .sel_pc_source(sel_pc_source), .sel_regdst(sel_regdst),
        .sel_memtoreg(sel_memtoreg), .sel_shift_src(sel_shift_src),
        .sel_shift_amt(sel_shift_amt), .sel_shift_reg(sel_shift_reg),
        .alu_op(alu_op), .exc_cause(exc_cause)
    );

    assign obs = {PC_write, wr, AB_load, aluout_load, EPC_load, sel_ir, reg_write,
                  sel_alusrca, sel_alusrcb, sel_iord, sel_pc_source, sel_regdst,
                  sel_memtoreg, sel_shift_src, sel_shift_amt, sel_shift_reg,
                  alu_op, exc_cause};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected control word for one step, written directly from the step table
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] opc,
                                     input logic [5:0] fn, input logic zero,
                                     input logic exc);
        ctl_t c;
        c     = '0;
        c.exc = exc;
        case (st)
            T_F3:  begin c.ir = 1; c.srcb = 2'b01; c.aluop = 3'b001; c.pc_write = 1; end
            T_DEC: begin c.ab_load = 1; c.srcb = 2'b11; c.aluop = 3'b001; c.aluout_load = 1; end
            T_EXR: begin
                c.srca = 1; c.aluout_load = 1;
                c.aluop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            end
            T_WBR: begin c.regdst = 2'b01; c.reg_write = 1; end
            T_EXI, T_MA: begin c.srca = 1; c.srcb = 2'b10; c.aluop = 3'b001; c.aluout_load = 1; end
            T_WBI: c.reg_write = 1;
            T_SHL: c.shreg = 3'b001;
            T_SHO: c.shreg = (fn == 6'h02) ? 3'b011 : 3'b010;
            T_WBS: begin c.memtoreg = 2'b10; c.regdst = 2'b01; c.reg_write = 1; end
            T_JR:  begin c.srca = 1; c.pc_write = 1; end
            T_J:   begin c.pcsrc = 2'b10; c.pc_write = 1; end
            T_BR:  begin
                c.srca = 1; c.aluop = 3'b010;
                if ((opc == 6'h04 && zero) || (opc == 6'h05 && !zero)) begin
                    c.pc_write = 1; c.pcsrc = 2'b01;
                end
            end
            T_R1, T_R2: c.iord = 1;
            T_WBM: begin c.iord = 1; c.memtoreg = 2'b01; c.reg_write = 1; end
            T_MW:  begin c.iord = 1; c.wr = 1; end
            T_EXC: begin
                c.srcb = 2'b01; c.aluop = 3'b010; c.epc_load = 1;
                c.pc_write = 1; c.pcsrc = 2'b11;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Drives one instruction from FETCH1; max_cycles > 0 aborts after that many
    task automatic run_instr(input string name, input logic [5:0] opc, input logic [5:0] fn,
                             input logic zero, input logic ovf, input int max_cycles);
        int   seq[$];
        logic new_exc;
        logic exc_now;
        ctl_t e;
        int   k;
        opcode = opc; funct = fn; alu_zero = zero; alu_overflow = ovf;
        seq = {T_F1, T_F2, T_F3, T_DEC};
        new_exc = cur_exc;
        if (opc == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h24: begin
                    seq.push_back(T_EXR);
                    if (fn != 6'h24 && ovf) begin seq.push_back(T_EXC); new_exc = 1; end
                    else seq.push_back(T_WBR);
                end
                6'h00, 6'h02: begin seq.push_back(T_SHL); seq.push_back(T_SHO); seq.push_back(T_WBS); end
                6'h08: seq.push_back(T_JR);
                default: begin seq.push_back(T_EXC); new_exc = 0; end
            endcase
        end else begin
            case (opc)
                6'h02: seq.push_back(T_J);
                6'h04, 6'h05: seq.push_back(T_BR);
                6'h08: begin
                    seq.push_back(T_EXI);
                    if (ovf) begin seq.push_back(T_EXC); new_exc = 1; end
                    else seq.push_back(T_WBI);
                end
                6'h23: begin seq.push_back(T_MA); seq.push_back(T_R1); seq.push_back(T_R2); seq.push_back(T_WBM); end
                6'h2b: begin seq.push_back(T_MA); seq.push_back(T_MW); end
                default: begin seq.push_back(T_EXC); new_exc = 0; end
            endcase
        end
        exc_now = cur_exc;
        foreach (seq[i]) begin
            if (seq[i] == T_EXC) exc_now = new_exc;
            exp_q.push_back(exp_ctl(seq[i], opc, fn, zero, exc_now));
        end
        k = 0;
        while (exp_q.size() > 0 && (max_cycles == 0 || k < max_cycles)) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            k++;
            check($sformatf("%s cyc%0d", name, k), {5'b0, obs}, {5'b0, e});
            check($sformatf("%s cyc%0d wr&reg_write", name, k),
                  {31'b0, wr & reg_write}, 32'd0);
        end
        exp_q.delete();
        if (max_cycles == 0) cur_exc = exc_now;
    endtask

    // Assert reset asynchronously, hold it, release on a falling edge
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check($sformatf("%s async", name), {5'b0, obs}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s held%0d", name, i), {5'b0, obs}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check($sformatf("%s release", name), {5'b0, obs}, 32'd0);
        cur_exc = 1'b0;
    endtask

    initial begin
        opcode = 6'h23; funct = 6'h00; alu_zero = 1'b0; alu_overflow = 1'b0;
        do_reset("reset_init");

        run_instr("lw",        6'h23, 6'h00, 0, 0, 0);
        run_instr("add",       6'h00, 6'h20, 0, 0, 0);
        run_instr("add_ovf",   6'h00, 6'h20, 0, 1, 0);
        run_instr("sub",       6'h00, 6'h22, 0, 0, 0);
        run_instr("and_ovf",   6'h00, 6'h24, 0, 1, 0);
        run_instr("beq_t",     6'h04, 6'h11, 1, 0, 0);
        run_instr("beq_nt",    6'h04, 6'h11, 0, 0, 0);
        run_instr("bne_t",     6'h05, 6'h11, 0, 0, 0);
        run_instr("bne_nt",    6'h05, 6'h11, 1, 0, 0);
        run_instr("bad_op",    6'h3f, 6'h20, 0, 0, 0);
        run_instr("addi",      6'h08, 6'h00, 0, 0, 0);
        run_instr("addi_ovf",  6'h08, 6'h00, 0, 1, 0);
        run_instr("bad_funct", 6'h00, 6'h3f, 0, 0, 0);
        run_instr("srl",       6'h00, 6'h02, 0, 0, 0);
        run_instr("sll",       6'h00, 6'h00, 0, 0, 0);
        run_instr("j",         6'h02, 6'h00, 0, 0, 0);
        run_instr("jr",        6'h00, 6'h08, 0, 0, 0);
        run_instr("sw",        6'h2b, 6'h00, 0, 1, 0);
        run_instr("sub_ovf",   6'h00, 6'h22, 1, 1, 0);

        // sw aborted in MEM_ADDR while exc_cause is 1
        run_instr("sw_abort",  6'h2b, 6'h00, 0, 0, 5);
        do_reset("reset_mid");
        run_instr("lw_after",  6'h23, 6'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
